// File: rtl/avalon_body_writer.sv
// Avalon-MM write master that sweeps a snapshot of per-body render state
// (radius, x, y, z) into a slave register file, four words per body.
`default_nettype none

module avalon_body_writer #(
  parameter int NUM_BODIES = 2,
  parameter int BASE_ADDR  = 0,
  parameter int ADDR_W     = 4,
  parameter int COORD_W    = 10
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               LD_VALID,
  input  logic [7:0]         LD_INDEX,
  input  logic [COORD_W-1:0] LD_RADIUS,
  input  logic [COORD_W-1:0] LD_X,
  input  logic [COORD_W-1:0] LD_Y,
  input  logic [COORD_W-1:0] LD_Z,
  input  logic               START,
  input  logic               AVM_WAITREQUEST,
  output logic               AVM_CS,
  output logic               AVM_WRITE,
  output logic [ADDR_W-1:0]  AVM_ADDR,
  output logic [3:0]         AVM_BYTE_EN,
  output logic [31:0]        AVM_WRITEDATA,
  output logic               BUSY,
  output logic               DONE,
  output logic [7:0]         OVERRUN
);

  localparam int NUM_WORDS = 4 * NUM_BODIES;
  localparam int CNT_W     = $clog2(NUM_WORDS);
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SNAP  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Word-flat buffers: entry 4*b+f holds field f (radius, x, y, z) of body b.
  logic [COORD_W-1:0] shadow [NUM_WORDS];
  logic [COORD_W-1:0] active [NUM_WORDS];
  logic [CNT_W-1:0]   word;
  logic               pending;
  logic [7:0]         overrun_cnt;

  assign OVERRUN = overrun_cnt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    AVM_WRITE     = 1'b0;
    AVM_CS        = 1'b0;
    AVM_BYTE_EN   = 4'b0000;
    AVM_ADDR      = '0;
    AVM_WRITEDATA = '0;
    BUSY          = 1'b0;
    DONE          = 1'b0;
    case (state)
      ST_IDLE: begin
        if (START) state_nxt = ST_SNAP;
      end
      ST_SNAP: begin
        BUSY      = 1'b1;
        state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        BUSY          = 1'b1;
        AVM_WRITE     = 1'b1;
        AVM_CS        = 1'b1;
        AVM_BYTE_EN   = 4'b1111;
        AVM_ADDR      = BASE + ADDR_W'(word);
        AVM_WRITEDATA = 32'(active[word]);
        if (!AVM_WAITREQUEST && word == LAST_WORD) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        BUSY = 1'b1;
        DONE = 1'b1;
        // A fresh START landing in DONE itself is honoured immediately.
        state_nxt = (pending || START) ? ST_SNAP : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      word        <= '0;
      pending     <= 1'b0;
      overrun_cnt <= 8'd0;
    end else begin
      for (int b = 0; b < NUM_BODIES; b++) begin
        if (LD_VALID && LD_INDEX == 8'(b)) begin
          shadow[4*b]   <= LD_RADIUS;
          shadow[4*b+1] <= LD_X;
          shadow[4*b+2] <= LD_Y;
          shadow[4*b+3] <= LD_Z;
        end
      end

      if (state == ST_SNAP) begin
        for (int i = 0; i < NUM_WORDS; i++) active[i] <= shadow[i];
        word <= '0;
      end else if (state == ST_WRITE && !AVM_WAITREQUEST) begin
        word <= word + 1'b1;
      end

      if (START && state != ST_IDLE) begin
        if (pending) begin
          if (overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
        end else if (state != ST_DONE) begin
          pending <= 1'b1;
        end
      end
      if (state == ST_DONE) pending <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_avalon_body_writer.sv
// Scoreboard bench for avalon_body_writer: expected bus writes are queued when
// a sweep is requested and matched as the master's writes are accepted.
`default_nettype none

module tb_avalon_body_writer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        LD_VALID;
  logic [7:0]  LD_INDEX;
  logic [9:0]  LD_RADIUS, LD_X, LD_Y, LD_Z;
  logic        START;
  logic        AVM_WAITREQUEST;
  logic        AVM_CS, AVM_WRITE;
  logic [3:0]  AVM_ADDR;
  logic [3:0]  AVM_BYTE_EN;
  logic [31:0] AVM_WRITEDATA;
  logic        BUSY, DONE;
  logic [7:0]  OVERRUN;

  avalon_body_writer #(
    .NUM_BODIES(2), .BASE_ADDR(0), .ADDR_W(4), .COORD_W(10)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .LD_VALID(LD_VALID), .LD_INDEX(LD_INDEX),
    .LD_RADIUS(LD_RADIUS), .LD_X(LD_X), .LD_Y(LD_Y), .LD_Z(LD_Z),
    .START(START), .AVM_WAITREQUEST(AVM_WAITREQUEST),
    .AVM_CS(AVM_CS), .AVM_WRITE(AVM_WRITE), .AVM_ADDR(AVM_ADDR),
    .AVM_BYTE_EN(AVM_BYTE_EN), .AVM_WRITEDATA(AVM_WRITEDATA),
    .BUSY(BUSY), .DONE(DONE), .OVERRUN(OVERRUN)
  );

  always #10 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;
  int done_hist [$];
  logic [35:0] sb [$];
  logic [9:0]  m_shadow [8];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Bus monitor: every accepted write must match the head of the scoreboard.
  always @(negedge CLK) begin
    logic [35:0] e;
    cyc++;
    if (DONE) begin
      done_cnt++;
      done_hist.push_back(cyc);
    end
    if (!RESET && AVM_WRITE && !AVM_WAITREQUEST) begin
      check("cs", {63'd0, AVM_CS}, 64'd1);
      check("byte_en", {60'd0, AVM_BYTE_EN}, 64'hF);
      if (sb.size() == 0) begin
        check("sb_empty", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        check("addr", {60'd0, AVM_ADDR}, {60'd0, e[35:32]});
        check("data", {32'd0, AVM_WRITEDATA}, {32'd0, e[31:0]});
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_sweep();
    for (int w = 0; w < 8; w++) sb.push_back({4'(w), 22'd0, m_shadow[w]});
  endtask

  task automatic load(input int idx, input int r, input int x, input int y, input int z);
    LD_VALID  = 1'b1;
    LD_INDEX  = 8'(idx);
    LD_RADIUS = 10'(r);
    LD_X      = 10'(x);
    LD_Y      = 10'(y);
    LD_Z      = 10'(z);
    tick();
    LD_VALID = 1'b0;
    if (idx < 2) begin
      m_shadow[4*idx]   = 10'(r);
      m_shadow[4*idx+1] = 10'(x);
      m_shadow[4*idx+2] = 10'(y);
      m_shadow[4*idx+3] = 10'(z);
    end
  endtask

  task automatic run_sweep(input int stall_addr, input int stall_len, input int mid_load,
                           input int extra_starts, input int exp_lat);
    int d0, n0, stall_left, target;
    push_sweep();
    d0     = done_cnt;
    target = d0 + 1 + ((extra_starts > 0) ? 1 : 0);
    START  = 1'b1;
    tick();
    START      = 1'b0;
    n0         = cyc;
    stall_left = stall_len;
    for (int k = 0; k < 200; k++) begin
      AVM_WAITREQUEST = AVM_WRITE && AVM_ADDR == 4'(stall_addr) && stall_left > 0;
      if (AVM_WAITREQUEST) stall_left--;
      LD_VALID = 1'b0;
      if (mid_load != 0 && k == 3) begin
        LD_VALID  = 1'b1;
        LD_INDEX  = 8'd0;
        LD_RADIUS = m_shadow[0];
        LD_X      = 10'd999;
        LD_Y      = m_shadow[2];
        LD_Z      = m_shadow[3];
        m_shadow[1] = 10'd999;
      end
      START = (k >= 2 && k < 2 + 2 * extra_starts && (k % 2) == 0);
      if (START && k == 2) push_sweep();
      tick();
      if (done_cnt >= target) break;
    end
    START = 1'b0;
    LD_VALID = 1'b0;
    AVM_WAITREQUEST = 1'b0;
    check("done_count", 64'(done_cnt), 64'(target));
    if (done_cnt >= target) begin
      check("done_latency", 64'(done_hist[d0] - n0), 64'(exp_lat));
      if (extra_starts > 0)
        check("followon_gap", 64'(done_hist[d0+1] - done_hist[d0]), 64'd10);
    end
    check("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_write"}, {63'd0, AVM_WRITE}, 64'd0);
    check({tag, "_cs"}, {63'd0, AVM_CS}, 64'd0);
    check({tag, "_addr"}, {60'd0, AVM_ADDR}, 64'd0);
    check({tag, "_be"}, {60'd0, AVM_BYTE_EN}, 64'd0);
    check({tag, "_wdata"}, {32'd0, AVM_WRITEDATA}, 64'd0);
    check({tag, "_busy"}, {63'd0, BUSY}, 64'd0);
    check({tag, "_done"}, {63'd0, DONE}, 64'd0);
    check({tag, "_overrun"}, {56'd0, OVERRUN}, 64'd0);
  endtask

  initial begin
    int d_before;
    RESET = 1'b1;
    LD_VALID = 1'b0;
    LD_INDEX = 8'd0;
    LD_RADIUS = '0; LD_X = '0; LD_Y = '0; LD_Z = '0;
    START = 1'b0;
    AVM_WAITREQUEST = 1'b0;
    for (int i = 0; i < 8; i++) m_shadow[i] = '0;
    repeat (3) tick();
    check_idle_outputs("por");
    RESET = 1'b0;
    tick();

    // Basic zero-wait sweep
    load(0, 5, 100, 200, 300);
    load(1, 7, 10, 20, 30);
    run_sweep(15, 0, 0, 0, 10);
    repeat (2) tick();

    // Stall three cycles on addr 2
    run_sweep(2, 3, 0, 0, 13);
    repeat (2) tick();

    // Mid-sweep load is not seen until the next snapshot
    run_sweep(15, 0, 1, 0, 10);
    tick();
    run_sweep(15, 0, 0, 0, 10);
    tick();

    // Out-of-range index is ignored
    load(5, 1, 2, 3, 4);
    run_sweep(15, 0, 0, 0, 10);
    tick();

    // Three STARTs during one sweep: one follow-on, two dropped
    run_sweep(15, 0, 0, 3, 10);
    check("overrun", {56'd0, OVERRUN}, 64'd2);
    tick();

    // Reset mid-sweep abandons it and clears everything
    push_sweep();
    d_before = done_cnt;
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (4) tick();
    check("pre_reset_write", {63'd0, AVM_WRITE}, 64'd1);
    RESET = 1'b1;
    tick();
    check_idle_outputs("rst1");
    tick();
    check_idle_outputs("rst2");
    RESET = 1'b0;
    sb.delete();
    for (int i = 0; i < 8; i++) m_shadow[i] = '0;
    repeat (12) tick();
    check("no_done_after_reset", 64'(done_cnt), 64'(d_before));
    run_sweep(15, 0, 0, 0, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
